// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and types for the register-file write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT  = 32;
  localparam int unsigned REG_NUM_LOG_DEFAULT = 5;
  localparam int unsigned WB_STARVE_LIMIT     = 3;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ALU,
    GRANT_MEM
  } grant_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry write-back holding buffer with valid/ready handshake and relative-age tracking.
module wb_slot #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned REG_NUM_LOG = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [REG_NUM_LOG-1:0] offer_addr,
  input  logic [WORD_WIDTH-1:0]  offer_value,
  input  logic                   grant,
  input  logic                   other_hold,
  input  logic                   other_load,
  input  logic                   wins_tie,
  output logic                   ready,
  output logic                   load,
  output logic                   full,
  output logic [REG_NUM_LOG-1:0] addr,
  output logic [WORD_WIDTH-1:0]  value,
  output logic                   younger
);

  assign ready = !rst && (!full || grant);
  // Writes to register 0 complete the handshake but never occupy the slot.
  assign load  = valid && ready && (offer_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      addr    <= '0;
      value   <= '0;
      younger <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      addr    <= offer_addr;
      value   <= offer_value;
      // Younger if the other entry survives this edge, or both load and we lose the tie.
      younger <= other_hold || (other_load && !wins_tie);
    end else begin
      if (grant) full <= 1'b0;
      if (other_load) younger <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates ALU and MEM write-back results onto the single RegFile write port and
// forwards buffered, not-yet-written values to operand read.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = WORD_WIDTH_DEFAULT,
  parameter int unsigned REG_NUM_LOG  = REG_NUM_LOG_DEFAULT,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   aluValid,
  output logic                   aluReady,
  input  logic [REG_NUM_LOG-1:0] aluAddr,
  input  logic [WORD_WIDTH-1:0]  aluValue,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic [REG_NUM_LOG-1:0] memAddr,
  input  logic [WORD_WIDTH-1:0]  memValue,
  output logic                   writeEnable,
  output logic [REG_NUM_LOG-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]  writeValue,
  input  logic [REG_NUM_LOG-1:0] queryAddr,
  output logic                   queryHit,
  output logic [WORD_WIDTH-1:0]  queryValue
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  grant_e                 grant;
  logic                   alu_load, alu_full, alu_younger;
  logic                   mem_load, mem_full, mem_younger;
  logic [REG_NUM_LOG-1:0] alu_addr, mem_addr;
  logic [WORD_WIDTH-1:0]  alu_value, mem_value;
  logic                   alu_grant, mem_grant;
  logic                   alu_hit, mem_hit;
  logic [STARVE_W-1:0]    starve;

  assign alu_grant = (grant == GRANT_ALU);
  assign mem_grant = (grant == GRANT_MEM);

  wb_slot #(.WORD_WIDTH(WORD_WIDTH), .REG_NUM_LOG(REG_NUM_LOG)) u_alu_slot (
    .clk         (clk),
    .rst         (rst),
    .valid       (aluValid),
    .offer_addr  (aluAddr),
    .offer_value (aluValue),
    .grant       (alu_grant),
    .other_hold  (mem_full && !mem_grant),
    .other_load  (mem_load),
    .wins_tie    (1'b0),
    .ready       (aluReady),
    .load        (alu_load),
    .full        (alu_full),
    .addr        (alu_addr),
    .value       (alu_value),
    .younger     (alu_younger)
  );

  wb_slot #(.WORD_WIDTH(WORD_WIDTH), .REG_NUM_LOG(REG_NUM_LOG)) u_mem_slot (
    .clk         (clk),
    .rst         (rst),
    .valid       (memValid),
    .offer_addr  (memAddr),
    .offer_value (memValue),
    .grant       (mem_grant),
    .other_hold  (alu_full && !alu_grant),
    .other_load  (alu_load),
    .wins_tie    (1'b1),
    .ready       (memReady),
    .load        (mem_load),
    .full        (mem_full),
    .addr        (mem_addr),
    .value       (mem_value),
    .younger     (mem_younger)
  );

  always_comb begin
    grant = GRANT_NONE;
    if (!rst) begin
      if (alu_full && mem_full) begin
        if (alu_addr == mem_addr)
          grant = alu_younger ? GRANT_MEM : GRANT_ALU;
        else if (starve == STARVE_W'(STARVE_LIMIT))
          grant = GRANT_ALU;
        else
          grant = GRANT_MEM;
      end else if (alu_full) begin
        grant = GRANT_ALU;
      end else if (mem_full) begin
        grant = GRANT_MEM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (alu_full && !alu_grant) begin
      if (starve != STARVE_W'(STARVE_LIMIT)) starve <= starve + STARVE_W'(1);
    end else begin
      starve <= '0;
    end
  end

  always_comb begin
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeValue  = '0;
    case (grant)
      GRANT_ALU: begin
        writeEnable = 1'b1;
        writeAddr   = alu_addr;
        writeValue  = alu_value;
      end
      GRANT_MEM: begin
        writeEnable = 1'b1;
        writeAddr   = mem_addr;
        writeValue  = mem_value;
      end
      default: ;
    endcase
  end

  assign alu_hit  = !rst && alu_full && (alu_addr == queryAddr) && (queryAddr != '0);
  assign mem_hit  = !rst && mem_full && (mem_addr == queryAddr) && (queryAddr != '0);
  assign queryHit = alu_hit || mem_hit;

  // On a double hit the younger entry holds the architecturally newest value.
  always_comb begin
    queryValue = '0;
    if (alu_hit && mem_hit)
      queryValue = alu_younger ? alu_value : mem_value;
    else if (alu_hit)
      queryValue = alu_value;
    else if (mem_hit)
      queryValue = mem_value;
  end

endmodule
